tag_2way_lru: RTL and testbench

Two-way set-associative tag store for the data cache: the next generation of the direct-mapped 1r1w tag RAM, adding per-way valid bits, optional dirty bits, hit compare, 1-bit-per-set LRU victim selection and a hardware invalidation sweep. It sits between the cache controller and the data arrays. It answers one lookup per cycle with one-cycle latency and accepts one fill per cycle.

---
 rtl/tag_2way_lru.sv | 250 +++++++++++++++++++++++++
 tb/tb_tag_2way_lru.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_2way_lru.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tag_2way_lru                                                 |
// | Description : Two-way set-associative tag store for the data cache.        |
// |               Per-way valid bits, optional dirty bits, hit compare, one    |
// |               LRU bit per set for victim choice, and a hardware            |
// |               invalidation sweep. One lookup per cycle with one-cycle      |
// |               latency. One fill per cycle.                                 |
// |                                                                            |
// | Parameters  : DRWIDTH  set index width (2**DRWIDTH sets)                   |
// |               TW       tag width, derived as 24-DRWIDTH                    |
// |                                                                            |
// | Ports       : clk, rst_n             clock, async active-low reset         |
// |               lkup_req/idx/tag       lookup request (taken when !busy)     |
// |               lkup_vld/hit/way/dirty lookup result, one cycle later        |
// |               vic_way/tag/valid      victim choice for a miss             |
// |               fill_req/idx/way/tag/dirty  tag write into one way           |
// |               dirty_set/idx/way      mark a way dirty                      |
// |               flush_req              start invalidation sweep              |
// |               busy, flush_done       sweep status, end-of-sweep pulse      |
// |                                                                            |
// | Build macro : TAG_DIRTY_EN  - when defined, dirty flops exist; otherwise   |
// |               lkup_dirty is 0 and the dirty inputs are ignored.            |
// |                                                                            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tag_2way_lru #(
  parameter  int DRWIDTH = 10,
  localparam int TW      = 24 - DRWIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  // lookup
  input  logic               lkup_req,
  input  logic [DRWIDTH-1:0] lkup_idx,
  input  logic [TW-1:0]      lkup_tag,
  output logic               lkup_vld,
  output logic               lkup_hit,
  output logic               lkup_way,
  output logic               lkup_dirty,
  output logic               vic_way,
  output logic [TW-1:0]      vic_tag,
  output logic               vic_valid,
  // fill
  input  logic               fill_req,
  input  logic [DRWIDTH-1:0] fill_idx,
  input  logic               fill_way,
  input  logic [TW-1:0]      fill_tag,
  input  logic               fill_dirty,
  // store-hit dirty marking
  input  logic               dirty_set,
  input  logic [DRWIDTH-1:0] dirty_idx,
  input  logic               dirty_way,
  // invalidation sweep
  input  logic               flush_req,
  output logic               busy,
  output logic               flush_done
);

  localparam int                 NSETS    = 2 ** DRWIDTH;
  localparam logic [DRWIDTH-1:0] LAST_SET = {DRWIDTH{1'b1}};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  state_t             state;
  logic [DRWIDTH-1:0] sweep_cnt;

  // Every request class is gated by the registered busy flag.
  logic lkup_acc;
  logic fill_acc;
  logic flush_acc;

  assign lkup_acc  = lkup_req  & ~busy;
  assign fill_acc  = fill_req  & ~busy;
  assign flush_acc = flush_req & ~busy;

  // --------------------------------------------------------------------------
  // Sweep FSM. Reset lands in SWEEP so the valid bits are cleared by the same
  // path as a software flush; busy/flush_done are registered with the state.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_SWEEP;
      sweep_cnt  <= '0;
      busy       <= 1'b1;
      flush_done <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      case (state)
        ST_SWEEP: begin
          if (sweep_cnt == LAST_SET) begin
            state      <= ST_IDLE;
            sweep_cnt  <= '0;
            busy       <= 1'b0;
            flush_done <= 1'b1;
          end else begin
            sweep_cnt <= sweep_cnt + DRWIDTH'(1);
          end
        end
        default: begin
          if (flush_acc) begin
            state     <= ST_SWEEP;
            sweep_cnt <= '0;
            busy      <= 1'b1;
          end
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Lookup request registers. The compare happens in the following cycle
  // against the arrays as they stand then, which gives write-first behaviour
  // for a fill/dirty_set accepted in the same cycle as the lookup.
  // --------------------------------------------------------------------------
  logic [DRWIDTH-1:0] q_idx;
  logic [TW-1:0]      q_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lkup_vld <= 1'b0;
      q_idx    <= '0;
      q_tag    <= '0;
    end else begin
      lkup_vld <= lkup_acc;
      if (lkup_acc) begin
        q_idx <= lkup_idx;
        q_tag <= lkup_tag;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Valid bits: the sweep clears one set per cycle, otherwise a fill sets one.
  // --------------------------------------------------------------------------
  logic [1:0][NSETS-1:0] valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (busy) begin
      valid[0][sweep_cnt] <= 1'b0;
      valid[1][sweep_cnt] <= 1'b0;
    end else if (fill_acc) begin
      valid[fill_way][fill_idx] <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Tag RAMs: synchronous write, asynchronous read from the registered index.
  // Contents are never cleared; valid bits qualify them.
  // --------------------------------------------------------------------------
  logic [TW-1:0] rd_tag [2];
  logic [1:0]    way_hit;

  for (genvar w = 0; w < 2; w++) begin : g_way
    logic [TW-1:0] mem [NSETS];

    always_ff @(posedge clk) begin
      if (fill_acc && (fill_way == 1'(w))) begin
        mem[fill_idx] <= fill_tag;
      end
    end

    assign rd_tag[w]  = mem[q_idx];
    assign way_hit[w] = valid[w][q_idx] && (rd_tag[w] == q_tag);
  end

  // --------------------------------------------------------------------------
  // Result outputs. Only one way can match when fills are correct, so the
  // hit way is simply whether way 1 matched.
  // --------------------------------------------------------------------------
  logic [NSETS-1:0] lru;   // per set: the least recently used way
  logic             vic_sel;

  always_comb begin
    vic_sel = lru[q_idx];
    if (!valid[0][q_idx]) begin
      vic_sel = 1'b0;
    end else if (!valid[1][q_idx]) begin
      vic_sel = 1'b1;
    end
  end

  assign lkup_hit  = lkup_vld & (|way_hit);
  assign lkup_way  = way_hit[1];
  assign vic_way   = vic_sel;
  assign vic_tag   = rd_tag[vic_sel];
  assign vic_valid = valid[vic_sel][q_idx];

  // --------------------------------------------------------------------------
  // LRU update. The hit update lands in the result cycle; a fill to the same
  // set in that cycle is written last so it takes precedence.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lru <= '0;
    end else begin
      if (lkup_hit) begin
        lru[q_idx] <= ~lkup_way;
      end
      if (fill_acc) begin
        lru[fill_idx] <= ~fill_way;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Dirty bits (optional).
  // --------------------------------------------------------------------------
`ifdef TAG_DIRTY_EN
  logic [1:0][NSETS-1:0] dirty;
  logic                  dset_acc;
  logic                  dirty_sel;

  assign dset_acc = dirty_set & ~busy;

  // dirty_set is written after the fill so a same set/way collision ends up
  // as fill_dirty OR 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dirty <= '0;
    end else if (busy) begin
      dirty[0][sweep_cnt] <= 1'b0;
      dirty[1][sweep_cnt] <= 1'b0;
    end else begin
      if (fill_acc) begin
        dirty[fill_way][fill_idx] <= fill_dirty;
      end
      if (dset_acc) begin
        dirty[dirty_way][dirty_idx] <= 1'b1;
      end
    end
  end

  // Hit way on a hit, victim way on a miss.
  assign dirty_sel  = (|way_hit) ? way_hit[1] : vic_sel;
  assign lkup_dirty = lkup_vld & dirty[dirty_sel][q_idx];
`else
  logic unused_dirty_inputs;

  assign unused_dirty_inputs = ^{fill_dirty, dirty_set, dirty_idx, dirty_way};
  assign lkup_dirty          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tag_2way_lru.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_tag_2way_lru                                              |
// | Description : Self-checking bench for tag_2way_lru (DRWIDTH=4). Stimulus   |
// |               updates a set/way reference model and queues the expected   |
// |               lookup results; a negedge monitor pops and compares.         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_tag_2way_lru;

  localparam int DRW   = 4;
  localparam int TW    = 24 - DRW;
  localparam int NSETS = 2 ** DRW;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           lkup_req;
  logic [DRW-1:0] lkup_idx;
  logic [TW-1:0]  lkup_tag;
  logic           lkup_vld, lkup_hit, lkup_way, lkup_dirty;
  logic           vic_way, vic_valid;
  logic [TW-1:0]  vic_tag;
  logic           fill_req;
  logic [DRW-1:0] fill_idx;
  logic           fill_way;
  logic [TW-1:0]  fill_tag;
  logic           fill_dirty;
  logic           dirty_set;
  logic [DRW-1:0] dirty_idx;
  logic           dirty_way;
  logic           flush_req;
  logic           busy, flush_done;

  always #5 clk = ~clk;

  tag_2way_lru #(.DRWIDTH(DRW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lkup_req   (lkup_req),
    .lkup_idx   (lkup_idx),
    .lkup_tag   (lkup_tag),
    .lkup_vld   (lkup_vld),
    .lkup_hit   (lkup_hit),
    .lkup_way   (lkup_way),
    .lkup_dirty (lkup_dirty),
    .vic_way    (vic_way),
    .vic_tag    (vic_tag),
    .vic_valid  (vic_valid),
    .fill_req   (fill_req),
    .fill_idx   (fill_idx),
    .fill_way   (fill_way),
    .fill_tag   (fill_tag),
    .fill_dirty (fill_dirty),
    .dirty_set  (dirty_set),
    .dirty_idx  (dirty_idx),
    .dirty_way  (dirty_way),
    .flush_req  (flush_req),
    .busy       (busy),
    .flush_done (flush_done)
  );

  typedef struct packed {
    logic          hit;
    logic          way;
    logic          dirty;
    logic          vway;
    logic [TW-1:0] vtag;
    logic          vvalid;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   passed = 0;
  bit   chk_en = 1'b0;

  // Reference model: per set and way, valid/dirty/tag, plus most recently used way.
  bit            m_val   [NSETS][2];
  bit            m_dirty [NSETS][2];
  logic [TW-1:0] m_tag   [NSETS][2];
  bit            mru     [NSETS];
  int            sweep_left = 0;
  bit            exp_busy = 1'b1;
  bit            exp_fd   = 1'b0;
  bit            pend_v   = 1'b0;
  bit            pend_hit, pend_way;
  int            pend_idx;
  logic [TW-1:0] pend_tag;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: actual %0h required %0h at t=%0t", name, act, req, $time);
  endtask

  task automatic do_lkup(input int idx, input int tag);
    lkup_req = 1'b1; lkup_idx = idx[DRW-1:0]; lkup_tag = tag[TW-1:0];
  endtask

  task automatic do_fill(input int idx, input int way, input int tag, input int d);
    fill_req = 1'b1; fill_idx = idx[DRW-1:0]; fill_way = way[0];
    fill_tag = tag[TW-1:0]; fill_dirty = d[0];
  endtask

  task automatic do_dset(input int idx, input int way);
    dirty_set = 1'b1; dirty_idx = idx[DRW-1:0]; dirty_way = way[0];
  endtask

  task automatic idle_inputs();
    lkup_req = 0; fill_req = 0; dirty_set = 0; flush_req = 0;
  endtask

  // One clock: the inputs already driven are applied at the coming edge, the
  // model follows, and the result due in the new cycle is queued.
  task automatic tick();
    bit   acc, was_sw, h0, h1;
    int   i;
    exp_t e;
    acc = (sweep_left == 0);
    @(posedge clk);
    #1;
    if (pend_v && pend_hit) mru[pend_idx] = pend_way;
    was_sw = (sweep_left > 0);
    pend_v = 1'b0;
    if (acc) begin
      if (fill_req) begin
        m_tag[fill_idx][fill_way]   = fill_tag;
        m_val[fill_idx][fill_way]   = 1'b1;
        m_dirty[fill_idx][fill_way] = fill_dirty;
        mru[fill_idx]               = fill_way;
      end
      if (dirty_set) m_dirty[dirty_idx][dirty_way] = 1'b1;
      if (lkup_req) begin
        pend_v = 1'b1; pend_idx = int'(lkup_idx); pend_tag = lkup_tag;
      end
    end
    exp_fd = 1'b0;
    if (was_sw) begin
      sweep_left--;
      if (sweep_left == 0) begin
        for (int s = 0; s < NSETS; s++)
          for (int w = 0; w < 2; w++) begin
            m_val[s][w] = 1'b0; m_dirty[s][w] = 1'b0;
          end
        exp_fd = 1'b1;
      end
    end else if (acc && flush_req) begin
      sweep_left = NSETS;
    end
    if (pend_v) begin
      i  = pend_idx;
      h0 = m_val[i][0] && (m_tag[i][0] == pend_tag);
      h1 = m_val[i][1] && (m_tag[i][1] == pend_tag);
      e.hit = h0 | h1;
      e.way = h1;
      if (!m_val[i][0])      e.vway = 1'b0;
      else if (!m_val[i][1]) e.vway = 1'b1;
      else                   e.vway = ~mru[i];
      e.vtag   = m_tag[i][e.vway];
      e.vvalid = m_val[i][e.vway];
`ifdef TAG_DIRTY_EN
      e.dirty = e.hit ? m_dirty[i][e.way] : m_dirty[i][e.vway];
`else
      e.dirty = 1'b0;
`endif
      sb.push_back(e);
      pend_hit = e.hit; pend_way = e.way;
    end
    exp_busy = (sweep_left > 0);
    idle_inputs();
  endtask

  task automatic start_after_reset();
    rst_n = 1'b1; sweep_left = NSETS; pend_v = 1'b0;
    exp_busy = 1'b1; exp_fd = 1'b0; chk_en = 1'b1;
  endtask

  task automatic wait_sweep();
    for (int n = 0; n < NSETS + 4 && sweep_left > 0; n++) tick();
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, exp_busy);
      chk("flush_done", flush_done, exp_fd);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("lkup_vld", lkup_vld, 1);
        if (lkup_vld) begin
          chk("lkup_hit", lkup_hit, mon_e.hit);
          chk("lkup_dirty", lkup_dirty, mon_e.dirty);
          if (mon_e.hit) begin
            chk("lkup_way", lkup_way, mon_e.way);
          end else begin
            chk("vic_way", vic_way, mon_e.vway);
            chk("vic_valid", vic_valid, mon_e.vvalid);
            if (mon_e.vvalid) chk("vic_tag", vic_tag, mon_e.vtag);
          end
        end
      end else begin
        chk("lkup_vld idle", lkup_vld, 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fi, fw, ft;
    rst_n = 1'b0;
    lkup_idx = '0; lkup_tag = '0; fill_idx = '0; fill_way = 0; fill_tag = '0;
    fill_dirty = 0; dirty_idx = '0; dirty_way = 0;
    idle_inputs();
    for (int s = 0; s < NSETS; s++) begin
      mru[s] = 0;
      for (int w = 0; w < 2; w++) begin
        m_val[s][w] = 0; m_dirty[s][w] = 0; m_tag[s][w] = '0;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", busy, 1);
    chk("reset lkup_vld", lkup_vld, 0);
    chk("reset flush_done", flush_done, 0);
    chk("reset lkup_hit", lkup_hit, 0);
    start_after_reset();
    wait_sweep();

    // Directed sequence from the test plan; lookups start in the flush_done cycle.
    do_lkup(5, 'h123);                       tick();
    do_fill(3, 0, 'h0ABCD, 0);               tick();
    do_lkup(3, 'h0ABCD);                     tick();
    do_lkup(3, 'h01111);                     tick();
    do_fill(3, 1, 'h02222, 0);               tick();
    do_lkup(3, 'h0ABCD);                     tick();
    do_lkup(3, 'h05555);                     tick();
    do_lkup(3, 'h02222);                     tick();
    do_lkup(3, 'h05555);                     tick();
    do_fill(7, 1, 'h00042, 0); do_lkup(7, 'h00042); tick();
    tick();
    do_dset(3, 0);                           tick();
    do_lkup(3, 'h0ABCD);                     tick();
    do_fill(9, 0, 'h00777, 1); do_dset(9, 0); tick();
    do_lkup(9, 'h00888);                     tick();
    do_flush_and_probe();
    do_lkup(3, 'h0ABCD);                     tick();
    do_lkup(7, 'h00042);                     tick();
    tick();

    // Reset in the middle of a lookup, then in the middle of a sweep.
    do_fill(2, 0, 'h00333, 0);               tick();
    do_lkup(2, 'h00333);                     tick();
    #1 rst_n = 1'b0; chk_en = 1'b0;
    #1 chk("async reset lkup_vld", lkup_vld, 0);
    chk("async reset busy", busy, 1);
    sb.delete(); pend_v = 1'b0;
    @(posedge clk); #1; start_after_reset();
    repeat (5) tick();
    #1 rst_n = 1'b0; chk_en = 1'b0;
    @(posedge clk); #1; start_after_reset();
    wait_sweep();

    // Randomized traffic on a few sets with a small tag pool to force hits.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(99) < 70) do_lkup($urandom_range(3), 'h100 + $urandom_range(3));
      if ($urandom_range(99) < 35) begin
        fi = $urandom_range(3); ft = 'h100 + $urandom_range(3); fw = $urandom_range(1);
        if (m_val[fi][1-fw] && m_tag[fi][1-fw] == ft[TW-1:0]) fw = 1 - fw;
        do_fill(fi, fw, ft, $urandom_range(1));
      end
      if ($urandom_range(99) < 20) do_dset($urandom_range(3), $urandom_range(1));
      if ($urandom_range(299) == 0) flush_req = 1'b1;
      tick();
    end
    wait_sweep();
    tick(); tick();
    chk("scoreboard drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Flush with lines valid; lookups driven throughout the sweep must be ignored.
  task automatic do_flush_and_probe();
    flush_req = 1'b1;
    tick();
    for (int n = 0; n < NSETS + 4 && sweep_left > 0; n++) begin
      do_lkup(3, 'h0ABCD);
      do_fill(4, 0, 'h0BEEF, 1);
      flush_req = 1'b1;
      tick();
    end
  endtask

endmodule
`default_nettype wire
